// File: rtl/lsu_mem_ctrl_if.sv
// Core-side request/response bundle of the load/store controller.
// The execute stage owns the master modport, the controller the slave modport.
interface lsu_mem_ctrl_if;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;

    modport master (
        output req, we, funct3, addr, wdata,
        input  busy, done, fault, rdata
    );

    modport slave (
        input  req, we, funct3, addr, wdata,
        output busy, done, fault, rdata
    );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// Load/store controller between the execute stage and a word-addressed data
// memory with combinational read. One access at a time; sub-word stores are
// a read-modify-write; rejected accesses never touch the memory port.
module lsu_mem_ctrl #(
    parameter int unsigned DEPTH = 32'd100
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    lsu_mem_ctrl_if.slave core,
    output logic          mem_we_o,
    output logic [31:0]   mem_addr_o,
    output logic [31:0]   mem_wd_o,
    input  logic [31:0]   mem_rd_i
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WRITE  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_RESP   = 3'd5
    } state_e;

    state_e      state_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [31:0] wdata_q;
    logic        busy_q;
    logic        done_q;
    logic        fault_q;
    logic [31:0] rdata_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wd_q;

    logic        acc_fault_d;
    logic [31:0] word_idx_d;

    // Illegal encoding, misalignment or word index beyond the memory.
    function automatic logic access_fault(input logic       we,
                                          input logic [2:0]  f3,
                                          input logic [31:0] addr);
        logic illegal;
        logic misaligned;
        logic out_of_range;
        if (we) begin
            illegal = f3[2] | (f3 == 3'b011);
        end else begin
            illegal = (f3 == 3'b011) | (f3 == 3'b110) | (f3 == 3'b111);
        end
        misaligned   = ((f3[1:0] == 2'b01) & addr[0]) |
                       ((f3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        out_of_range = ({2'b00, addr[31:2]} >= DEPTH);
        return illegal | misaligned | out_of_range;
    endfunction

    // Pick the addressed byte/half out of a word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  lane);
        logic [31:0] shifted;
        logic [15:0] half;
        logic        sign;
        shifted = word >> {lane, 3'b000};
        half    = lane[1] ? word[31:16] : word[15:0];
        case (f3[1:0])
            2'b00: begin
                sign = ~f3[2] & shifted[7];
                return {{24{sign}}, shifted[7:0]};
            end
            2'b01: begin
                sign = ~f3[2] & half[15];
                return {{16{sign}}, half};
            end
            default: begin
                return word;
            end
        endcase
    endfunction

    // Overlay the store byte/half onto the word read back from memory.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [31:0] merged;
        merged = old;
        case (f3[1:0])
            2'b00: begin
                case (lane)
                    2'b00:   merged[7:0]   = wd[7:0];
                    2'b01:   merged[15:8]  = wd[7:0];
                    2'b10:   merged[23:16] = wd[7:0];
                    2'b11:   merged[31:24] = wd[7:0];
                    default: merged        = old;
                endcase
            end
            2'b01: begin
                if (lane[1]) begin
                    merged[31:16] = wd[15:0];
                end else begin
                    merged[15:0] = wd[15:0];
                end
            end
            default: begin
                merged = wd;
            end
        endcase
        return merged;
    endfunction

    // Decode the incoming request: rejection verdict and target word index.
    always_comb begin
        acc_fault_d = access_fault(core.we, core.funct3, core.addr);
        word_idx_d  = {2'b00, core.addr[31:2]};
    end

    // Access sequencer; every output is a register updated alongside the state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            funct3_q   <= 3'b000;
            lane_q     <= 2'b00;
            wdata_q    <= 32'h0000_0000;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            fault_q    <= 1'b0;
            rdata_q    <= 32'h0000_0000;
            mem_we_q   <= 1'b0;
            mem_addr_q <= 32'h0000_0000;
            mem_wd_q   <= 32'h0000_0000;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (core.req) begin
                        funct3_q <= core.funct3;
                        lane_q   <= core.addr[1:0];
                        wdata_q  <= core.wdata;
                        busy_q   <= 1'b1;
                        if (acc_fault_d) begin
                            state_q <= S_RESP;
                            done_q  <= 1'b1;
                            fault_q <= 1'b1;
                        end else if (!core.we) begin
                            state_q    <= S_LOAD;
                            mem_addr_q <= word_idx_d;
                        end else if (core.funct3[1:0] == 2'b10) begin
                            state_q    <= S_WRITE;
                            mem_addr_q <= word_idx_d;
                            mem_we_q   <= 1'b1;
                            mem_wd_q   <= core.wdata;
                        end else begin
                            state_q    <= S_RMW_RD;
                            mem_addr_q <= word_idx_d;
                        end
                    end else begin
                        busy_q <= 1'b0;
                    end
                end
                S_LOAD: begin
                    rdata_q    <= load_extract(mem_rd_i, funct3_q, lane_q);
                    mem_addr_q <= 32'h0000_0000;
                    done_q     <= 1'b1;
                    state_q    <= S_RESP;
                end
                S_RMW_RD: begin
                    // mem_wd doubles as the merge register for the write cycle.
                    mem_wd_q <= store_merge(mem_rd_i, wdata_q, funct3_q, lane_q);
                    mem_we_q <= 1'b1;
                    state_q  <= S_RMW_WR;
                end
                S_WRITE, S_RMW_WR: begin
                    mem_we_q   <= 1'b0;
                    mem_wd_q   <= 32'h0000_0000;
                    mem_addr_q <= 32'h0000_0000;
                    done_q     <= 1'b1;
                    state_q    <= S_RESP;
                end
                S_RESP: begin
                    done_q  <= 1'b0;
                    fault_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q    <= S_IDLE;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                    fault_q    <= 1'b0;
                    mem_we_q   <= 1'b0;
                    mem_addr_q <= 32'h0000_0000;
                    mem_wd_q   <= 32'h0000_0000;
                end
            endcase
        end
    end

    assign core.busy  = busy_q;
    assign core.done  = done_q;
    assign core.fault = fault_q;
    assign core.rdata = rdata_q;
    assign mem_we_o   = mem_we_q;
    assign mem_addr_o = mem_addr_q;
    assign mem_wd_o   = mem_wd_q;

endmodule
